// File: rtl/tap_trig_pkg.sv
// Shared TAP definitions: control bus layout, field extractors and trigger FSM encoding.
// Bus layout: [0] gt, [1] et, [2] lt, [3] trig_en, [4 +: TAP_THR_W] thr.
package tap_trig_pkg;

    localparam int unsigned TAP_THR_W      = 14;
    localparam int unsigned N_TAP_CTL_SIZE = 4 + TAP_THR_W;

    localparam logic [1:0] ST_DISABLED = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_HOLDOFF  = 2'd2;

    typedef logic [N_TAP_CTL_SIZE-1:0] tap_ctl_t;

    function automatic logic tap_gt(input tap_ctl_t ctl);
        return ctl[0];
    endfunction

    function automatic logic tap_et(input tap_ctl_t ctl);
        return ctl[1];
    endfunction

    function automatic logic tap_lt(input tap_ctl_t ctl);
        return ctl[2];
    endfunction

    function automatic logic tap_trig_en(input tap_ctl_t ctl);
        return ctl[3];
    endfunction

    function automatic logic [TAP_THR_W-1:0] tap_thr(input tap_ctl_t ctl);
        return ctl[4 +: TAP_THR_W];
    endfunction

endpackage

// File: rtl/tap_cmp.sv
// Combinational threshold compare; hit is the OR of the selected unsigned relations.
module tap_cmp #(
    parameter int unsigned SMP_W = 14
) (
    input  logic [SMP_W-1:0] smp,
    input  logic [SMP_W-1:0] thr,
    input  logic             gt,
    input  logic             et,
    input  logic             lt,
    output logic             hit
);

    assign hit = (gt && (smp > thr)) || (et && (smp == thr)) || (lt && (smp < thr));

endmodule

// File: rtl/tap_trig.sv
// Edge-qualified threshold trigger with programmable holdoff.
// Optional saturating trigger counter enabled by defining TAP_TRIG_CNT_EN.
module tap_trig
    import tap_trig_pkg::*;
#(
    parameter int unsigned HOLDOFF = 16,
    parameter int unsigned SMP_W   = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_TAP_CTL_SIZE-1:0] ctl,
    input  logic [SMP_W-1:0]          smp,
    input  logic                      smp_vld,
    output logic                      trig,
    output logic [SMP_W-1:0]          trig_smp,
    output logic                      busy
`ifdef TAP_TRIG_CNT_EN
    ,
    output logic [31:0]               trig_cnt
`endif
);

    localparam int unsigned     CNT_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLDOFF - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_d_q, hit_d_d;
    logic             trig_q, trig_d;
    logic [SMP_W-1:0] trig_smp_q, trig_smp_d;
    logic             hit;
    logic             trig_en;
    logic             fire;

    tap_cmp #(
        .SMP_W (SMP_W)
    ) u_cmp (
        .smp (smp),
        .thr (tap_thr(ctl)),
        .gt  (tap_gt(ctl)),
        .et  (tap_et(ctl)),
        .lt  (tap_lt(ctl)),
        .hit (hit)
    );

    assign trig_en = tap_trig_en(ctl);
    assign fire    = smp_vld && hit && !hit_d_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hit_d_d    = hit_d_q;
        trig_d     = 1'b0;
        trig_smp_d = trig_smp_q;
        if (!trig_en) begin
            // Forcing hit_d high makes re-arming wait for a non-hit sample first.
            state_d = ST_DISABLED;
            cnt_d   = '0;
            hit_d_d = 1'b1;
        end else begin
            if (smp_vld) begin
                hit_d_d = hit;
            end
            case (state_q)
                ST_DISABLED: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (fire) begin
                        trig_d     = 1'b1;
                        trig_smp_d = smp;
                        cnt_d      = CNT_LOAD;
                        state_d    = ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt_q == '0) begin
                        state_d = ST_ARMED;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = ST_DISABLED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_DISABLED;
            cnt_q      <= '0;
            hit_d_q    <= 1'b1;
            trig_q     <= 1'b0;
            trig_smp_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hit_d_q    <= hit_d_d;
            trig_q     <= trig_d;
            trig_smp_q <= trig_smp_d;
        end
    end

    assign trig     = trig_q;
    assign trig_smp = trig_smp_q;
    assign busy     = (state_q == ST_HOLDOFF);

`ifdef TAP_TRIG_CNT_EN
    logic [31:0] trig_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_cnt_q <= '0;
        end else if (trig_q && (trig_cnt_q != 32'hFFFF_FFFF)) begin
            trig_cnt_q <= trig_cnt_q + 32'd1;
        end
    end

    assign trig_cnt = trig_cnt_q;
`endif

endmodule

// File: tb/tb_tap_trig.sv
// Directed bench for tap_trig; define TAP_TRIG_CNT_EN to also exercise the trigger counter.
module tb_tap_trig;
    import tap_trig_pkg::*;

    localparam int unsigned HOLDOFF = 16;
    localparam int unsigned SMP_W   = 14;

    logic                      clk;
    logic                      rst;
    logic [N_TAP_CTL_SIZE-1:0] ctl;
    logic [SMP_W-1:0]          smp;
    logic                      smp_vld;
    logic                      trig;
    logic [SMP_W-1:0]          trig_smp;
    logic                      busy;
`ifdef TAP_TRIG_CNT_EN
    logic [31:0]               trig_cnt;
`endif

    int n_checks;
    int n_errors;
    int n_trig;
    int n_busy;

    tap_trig #(
        .HOLDOFF (HOLDOFF),
        .SMP_W   (SMP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ctl      (ctl),
        .smp      (smp),
        .smp_vld  (smp_vld),
        .trig     (trig),
        .trig_smp (trig_smp),
        .busy     (busy)
`ifdef TAP_TRIG_CNT_EN
        ,
        .trig_cnt (trig_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ctl(input logic gt, input logic et, input logic lt, input logic en,
                           input logic [TAP_THR_W-1:0] thr);
        ctl = {thr, en, lt, et, gt};
    endtask

    // Present one sample, let one edge pass, return 1 ns after that edge.
    task automatic cycle(input logic v, input logic [SMP_W-1:0] s);
        smp_vld = v;
        smp     = s;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input logic [SMP_W-1:0] s);
        repeat (HOLDOFF) cycle(1'b1, s);
    endtask

`ifdef TAP_TRIG_CNT_EN
    task automatic fire_once;
        cycle(1'b1, 14'd50);
        cycle(1'b1, 14'd200);
        drain(14'd50);
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        smp_vld  = 1'b0;
        smp      = '0;
        set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 14'd100);
        #3;
        check("rst_trig", {31'd0, trig}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_trig_smp", {18'd0, trig_smp}, 32'd0);
`ifdef TAP_TRIG_CNT_EN
        check("rst_trig_cnt", trig_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Quiet arm: a hit seen right after arming must not trigger.
        cycle(1'b1, 14'd200);
        check("quiet_arm_0", {31'd0, trig}, 32'd0);
        cycle(1'b1, 14'd200);
        check("quiet_arm_1", {31'd0, trig}, 32'd0);
        cycle(1'b1, 14'd50);
        check("quiet_arm_low", {31'd0, trig}, 32'd0);
        cycle(1'b1, 14'd200);
        check("first_trig", {31'd0, trig}, 32'd1);
        check("first_trig_smp", {18'd0, trig_smp}, 32'd200);
        check("first_busy", {31'd0, busy}, 32'd1);

        // Earliest re-trigger: 17 cycles apart, busy for 16.
        n_busy = 1;
        n_trig = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 14'd50);
            n_busy += int'(busy);
            n_trig += int'(trig);
        end
        check("holdoff_busy_len", n_busy, 32'd16);
        check("holdoff_no_trig", n_trig, 32'd0);
        cycle(1'b1, 14'd200);
        check("retrig_at_17", {31'd0, trig}, 32'd1);

        // Alternating 50/200: the edge on the final holdoff cycle is ignored.
        n_trig = 0;
        n_busy = 1;
        for (int i = 1; i <= 17; i++) begin
            cycle(1'b1, (i % 2 == 1) ? 14'd50 : 14'd200);
            n_trig += int'(trig);
            n_busy += int'(busy);
        end
        check("alt_no_trig", n_trig, 32'd0);
        check("alt_busy_len", n_busy, 32'd16);
        cycle(1'b1, 14'd200);
        check("alt_trig_at_18", {31'd0, trig}, 32'd1);
        drain(14'd50);

        // Equal mode.
        set_ctl(1'b0, 1'b1, 1'b0, 1'b1, 14'd1000);
        cycle(1'b1, 14'd999);
        check("et_999", {31'd0, trig}, 32'd0);
        cycle(1'b1, 14'd1000);
        check("et_1000", {31'd0, trig}, 32'd1);
        drain(14'd999);

        // Less-than mode.
        set_ctl(1'b0, 1'b0, 1'b1, 1'b1, 14'd1000);
        cycle(1'b1, 14'd1001);
        check("lt_1001", {31'd0, trig}, 32'd0);
        cycle(1'b1, 14'd999);
        check("lt_999", {31'd0, trig}, 32'd1);
        drain(14'd1001);

        // No mode selected never triggers.
        set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 14'd1000);
        n_trig = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, (i % 2 == 0) ? 14'd1001 : 14'd999);
            n_trig += int'(trig);
        end
        cycle(1'b1, 14'd1000);
        n_trig += int'(trig);
        check("no_mode", n_trig, 32'd0);

        // Disable mid-holdoff, then re-arm quietly.
        set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 14'd100);
        cycle(1'b1, 14'd50);
        cycle(1'b1, 14'd200);
        check("dis_trig", {31'd0, trig}, 32'd1);
        repeat (4) cycle(1'b1, 14'd50);
        check("dis_busy_before", {31'd0, busy}, 32'd1);
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 14'd100);
        cycle(1'b1, 14'd50);
        check("dis_busy_after", {31'd0, busy}, 32'd0);
        set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 14'd100);
        n_trig = 0;
        cycle(1'b1, 14'd200);
        n_trig += int'(trig);
        cycle(1'b1, 14'd50);
        n_trig += int'(trig);
        check("dis_rearm_quiet", n_trig, 32'd0);
        cycle(1'b1, 14'd200);
        check("dis_rearm_trig", {31'd0, trig}, 32'd1);
        drain(14'd50);

        // Asynchronous reset mid-holdoff.
        cycle(1'b1, 14'd50);
        cycle(1'b1, 14'd222);
        check("rst_mid_trig", {31'd0, trig}, 32'd1);
        repeat (4) cycle(1'b1, 14'd50);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_trig_smp", {18'd0, trig_smp}, 32'd0);
        rst = 1'b0;
        n_trig = 0;
        cycle(1'b1, 14'd200);
        n_trig += int'(trig);
        cycle(1'b1, 14'd50);
        n_trig += int'(trig);
        check("rst_rearm_quiet", n_trig, 32'd0);
        cycle(1'b1, 14'd200);
        check("rst_rearm_trig", {31'd0, trig}, 32'd1);
        check("rst_rearm_smp", {18'd0, trig_smp}, 32'd200);
        drain(14'd50);

        // smp_vld gaps: invalid samples are ignored, holdoff keeps counting.
        cycle(1'b1, 14'd50);
        n_trig = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 14'd200);
            n_trig += int'(trig);
        end
        check("gap_invalid_quiet", n_trig, 32'd0);
        cycle(1'b1, 14'd300);
        check("gap_trig", {31'd0, trig}, 32'd1);
        check("gap_trig_smp", {18'd0, trig_smp}, 32'd300);
        repeat (HOLDOFF) cycle(1'b0, 14'd50);
        check("gap_holdoff_runs", {31'd0, busy}, 32'd0);

`ifdef TAP_TRIG_CNT_EN
        rst = 1'b1;
        #2;
        rst = 1'b0;
        repeat (5) fire_once();
        check("cnt_five", trig_cnt, 32'd5);
        dut.trig_cnt_q = 32'hFFFF_FFFE;
        repeat (3) fire_once();
        check("cnt_saturate", trig_cnt, 32'hFFFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
